fsm_status_monitor: RTL and testbench
=====================================

FSM_STATUS_MONITOR -- requirements
Module: fsm_status_monitor

Interface
REQ-001 Parameter EXP_COUNT_LEN, default 8'd4: expected number of sampled cycles spent in COUNT; used only when MON_DWELL_CHECK_EN is defined.
REQ-002 clk  input  1  clock; all state updates on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 code_in  input  8  status code driven by the sequencer FSM: 0=IDLE, 10=COUNT, 5=WAIT, 15=DONE, 17=FAULT; any other value is UNKNOWN.
REQ-005 sample_en  input  1  qualifies code_in; when low, no internal state changes except err_clr handling.
REQ-006 err_clr  input  1  clears seq_err and err_count.
REQ-007 state_dec  output  3  decoded current state: 0 IDLE, 1 COUNT, 2 WAIT, 3 DONE, 4 FAULT, 7 UNKNOWN.
REQ-008 trans_pulse  output  1  one-cycle pulse on any accepted code change.
REQ-009 seq_err  output  1  sticky illegal-sequence flag.
REQ-010 err_count  output  4  number of illegal events, saturating at 15.
REQ-011 count_len  output  8  dwell length of the last completed COUNT phase.
REQ-012 len_valid  output  1  one-cycle pulse when count_len updates.
REQ-013 rounds  output  8  completed DONE->IDLE rounds, wrapping 255->0.

Function
REQ-014 The block SHALL hold a registered copy code_q, loaded from code_in on each rising edge with sample_en=1; state_dec SHALL be the decode of code_q, visible the cycle after sampling.
REQ-015 A transition SHALL be an edge with sample_en=1 and code_in != code_q; trans_pulse SHALL be 1 for exactly the following cycle; equal codes are a hold, not a transition.
REQ-016 Legal transitions: IDLE->COUNT, COUNT->WAIT, WAIT->DONE, DONE->IDLE, FAULT->IDLE, UNKNOWN->IDLE; every other transition, including any entry into FAULT or UNKNOWN and a change between two different UNKNOWN values, SHALL be illegal.
REQ-017 An illegal transition SHALL set seq_err=1 and increment err_count by 1, saturating at 15, on the same edge as the code_q update.
REQ-018 seq_err SHALL remain 1 until err_clr or reset; err_clr=1 SHALL clear seq_err and err_count to 0 regardless of sample_en.
REQ-019 Simultaneous err_clr and illegal transition: the error SHALL win; seq_err=1 and err_count=1 after the edge.
REQ-020 Dwell counter: SHALL load 1 on the edge entering COUNT, increment on each sample_en=1 edge with code_in=COUNT while code_q=COUNT, and saturate at 255.
REQ-021 On COUNT->WAIT: count_len SHALL take the dwell value and len_valid SHALL pulse for one cycle; COUNT->any other code SHALL discard the dwell with no len_valid.
REQ-022 DONE->IDLE SHALL increment rounds modulo 256; no other transition SHALL change rounds.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 With reset=1 at a rising edge: code_q=0 (state_dec=0), trans_pulse=0, seq_err=0, err_count=0, count_len=0, len_valid=0, rounds=0, dwell=0; reset SHALL take priority over every other input.
REQ-025 Reset asserted mid-COUNT SHALL discard the dwell; the first sampled code after reset SHALL be checked against IDLE.

Configuration
REQ-026 Macro MON_DWELL_CHECK_EN: when defined, a COUNT->WAIT transition with dwell != EXP_COUNT_LEN SHALL be treated as an illegal event per REQ-017, while count_len and len_valid still update.
REQ-027 When MON_DWELL_CHECK_EN is not defined, dwell length SHALL never cause seq_err, and EXP_COUNT_LEN SHALL have no effect.

Verification
REQ-028 Reset, then sample_en=1 with codes 0,10,10,10,10,5,15,0 -> state_dec 0,1,1,1,1,2,3,0; len_valid pulses once with count_len=4; rounds=1; seq_err=0.
REQ-029 Codes 0,5 (IDLE->WAIT) -> seq_err=1, err_count=1; then err_clr=1 for one cycle -> seq_err=0, err_count=0.
REQ-030 Sixteen alternating 0,17 pairs -> err_count saturates at 15, seq_err=1; the 17->0 transitions raise no error.
REQ-031 COUNT held 300 sampled cycles then 5 -> count_len=255; with MON_DWELL_CHECK_EN defined and EXP_COUNT_LEN=4, also seq_err=1 and err_count=1; undefined -> seq_err=0.
REQ-032 sample_en=0 while code_in toggles 0/10/5 -> no change to state_dec, trans_pulse, or counters; err_clr with a simultaneous illegal event -> err_count=1.
REQ-033 256 full rounds -> rounds wraps to 0; reset asserted mid-COUNT -> all outputs 0 next cycle, no len_valid.

Source files
------------

// File: rtl/fsm_status_monitor.sv
// Passive monitor for the sequencer status code: decodes state, flags illegal
// transitions, measures COUNT dwell and counts rounds. Optional: MON_DWELL_CHECK_EN.
module fsm_status_monitor #(
  parameter logic [7:0] EXP_COUNT_LEN = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_in,
  input  logic       sample_en,
  input  logic       err_clr,
  output logic [2:0] state_dec,
  output logic       trans_pulse,
  output logic       seq_err,
  output logic [3:0] err_count,
  output logic [7:0] count_len,
  output logic       len_valid,
  output logic [7:0] rounds
);

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 3;

  localparam logic [CW-1:0] C_IDLE  = CW'(0);
  localparam logic [CW-1:0] C_COUNT = CW'(10);
  localparam logic [CW-1:0] C_WAIT  = CW'(5);
  localparam logic [CW-1:0] C_DONE  = CW'(15);
  localparam logic [CW-1:0] C_FAULT = CW'(17);

  localparam logic [SW-1:0] S_IDLE  = SW'(0);
  localparam logic [SW-1:0] S_COUNT = SW'(1);
  localparam logic [SW-1:0] S_WAIT  = SW'(2);
  localparam logic [SW-1:0] S_DONE  = SW'(3);
  localparam logic [SW-1:0] S_FAULT = SW'(4);
  localparam logic [SW-1:0] S_UNK   = SW'(7);

  function automatic logic [SW-1:0] decode(input logic [CW-1:0] c);
    case (c)
      C_IDLE:  decode = S_IDLE;
      C_COUNT: decode = S_COUNT;
      C_WAIT:  decode = S_WAIT;
      C_DONE:  decode = S_DONE;
      C_FAULT: decode = S_FAULT;
      default: decode = S_UNK;
    endcase
  endfunction

  logic [CW-1:0] code_q;
  logic [7:0]    dwell;

  logic [SW-1:0] in_s;
  logic          is_change;
  logic          legal;
  logic          cnt_to_wait;
  logic          dwell_bad;
  logic          err_event;
  logic          round_done;
  logic [7:0]    dwell_nxt;
  logic          seq_err_nxt;
  logic [3:0]    err_count_nxt;

  // Transition classification against the currently held state
  always_comb begin
    in_s        = decode(code_in);
    is_change   = sample_en && (code_in != code_q);
    legal       = 1'b0;
    case (state_dec)
      S_IDLE:  legal = (in_s == S_COUNT);
      S_COUNT: legal = (in_s == S_WAIT);
      S_WAIT:  legal = (in_s == S_DONE);
      S_DONE:  legal = (in_s == S_IDLE);
      S_FAULT: legal = (in_s == S_IDLE);
      S_UNK:   legal = (in_s == S_IDLE);
      default: legal = 1'b0;
    endcase
    cnt_to_wait = is_change && (state_dec == S_COUNT) && (in_s == S_WAIT);
    round_done  = is_change && (state_dec == S_DONE) && (in_s == S_IDLE);
  end

`ifdef MON_DWELL_CHECK_EN
  assign dwell_bad = cnt_to_wait && (dwell != EXP_COUNT_LEN);
`else
  logic unused_exp_len;
  assign unused_exp_len = ^EXP_COUNT_LEN;
  assign dwell_bad      = 1'b0;
`endif

  assign err_event = (is_change && !legal) || dwell_bad;

  // Next values for the dwell counter and error bookkeeping
  always_comb begin
    dwell_nxt     = dwell;
    seq_err_nxt   = seq_err;
    err_count_nxt = err_count;

    if (is_change) begin
      dwell_nxt = (in_s == S_COUNT) ? 8'd1 : 8'd0;
    end else if (sample_en && (state_dec == S_COUNT) && (dwell != 8'd255)) begin
      dwell_nxt = dwell + 8'd1;
    end

    // An error on the same edge as a clear leaves exactly one error recorded
    if (err_event) begin
      seq_err_nxt   = 1'b1;
      if (err_clr) begin
        err_count_nxt = 4'd1;
      end else if (err_count != 4'd15) begin
        err_count_nxt = err_count + 4'd1;
      end
    end else if (err_clr) begin
      seq_err_nxt   = 1'b0;
      err_count_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q      <= C_IDLE;
      state_dec   <= S_IDLE;
      dwell       <= 8'd0;
      trans_pulse <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= 4'd0;
      count_len   <= 8'd0;
      len_valid   <= 1'b0;
      rounds      <= 8'd0;
    end else begin
      if (sample_en) begin
        code_q    <= code_in;
        state_dec <= in_s;
      end
      dwell       <= dwell_nxt;
      trans_pulse <= is_change;
      seq_err     <= seq_err_nxt;
      err_count   <= err_count_nxt;
      len_valid   <= cnt_to_wait;
      if (cnt_to_wait) begin
        count_len <= dwell;
      end
      if (round_done) begin
        rounds <= rounds + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_status_monitor.sv
// Directed self-checking bench for fsm_status_monitor (EXP_COUNT_LEN=4).
module tb_fsm_status_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] code_in;
  logic       sample_en;
  logic       err_clr;
  logic [2:0] state_dec;
  logic       trans_pulse;
  logic       seq_err;
  logic [3:0] err_count;
  logic [7:0] count_len;
  logic       len_valid;
  logic [7:0] rounds;

  int total = 0;
  int bad   = 0;

`ifdef MON_DWELL_CHECK_EN
  localparam logic DWELL_ERR = 1'b1;
`else
  localparam logic DWELL_ERR = 1'b0;
`endif

  fsm_status_monitor #(.EXP_COUNT_LEN(8'd4)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .sample_en(sample_en),
    .err_clr(err_clr), .state_dec(state_dec), .trans_pulse(trans_pulse),
    .seq_err(seq_err), .err_count(err_count), .count_len(count_len),
    .len_valid(len_valid), .rounds(rounds)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] c, input logic e, input logic clr);
    code_in = c; sample_en = e; err_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [7:0] c, input logic e);
    reset = 1'b1; code_in = c; sample_en = e; err_clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(8'd10, 1'b1);
    total++;
    if ({state_dec, trans_pulse, seq_err, err_count, count_len, len_valid, rounds} !== 26'd0) begin
      bad++; $display("FAIL reset_state got=%h want=0",
        {state_dec, trans_pulse, seq_err, err_count, count_len, len_valid, rounds});
    end
  endtask

  task automatic test_nominal;
    logic [7:0] codes [8] = '{8'd0, 8'd10, 8'd10, 8'd10, 8'd10, 8'd5, 8'd15, 8'd0};
    logic [2:0] exp_s [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_t [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_l [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset(8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(codes[i], 1'b1, 1'b0);
      total++;
      if ({state_dec, trans_pulse, len_valid} !== {exp_s[i], exp_t[i], exp_l[i]}) begin
        bad++; $display("FAIL nominal_step%0d got s=%0d t=%b l=%b want s=%0d t=%b l=%b",
          i, state_dec, trans_pulse, len_valid, exp_s[i], exp_t[i], exp_l[i]);
      end
    end
    total++;
    if ({count_len, rounds, seq_err, err_count} !== {8'd4, 8'd1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL nominal_final got len=%0d rounds=%0d err=%b cnt=%0d want 4 1 0 0",
        count_len, rounds, seq_err, err_count);
    end
  endtask

  task automatic test_illegal_clr;
    do_reset(8'd0, 1'b0);
    step(8'd0, 1'b1, 1'b0);
    step(8'd5, 1'b1, 1'b0);
    total++;
    if ({seq_err, err_count, state_dec} !== {1'b1, 4'd1, 3'd2}) begin
      bad++; $display("FAIL idle_to_wait got err=%b cnt=%0d s=%0d want 1 1 2", seq_err, err_count, state_dec);
    end
    step(8'd5, 1'b1, 1'b1);
    total++;
    if ({seq_err, err_count} !== {1'b0, 4'd0}) begin
      bad++; $display("FAIL err_clr got err=%b cnt=%0d want 0 0", seq_err, err_count);
    end
  endtask

  task automatic test_saturation;
    do_reset(8'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(8'd0, 1'b1, 1'b0);
      total++;
      if (err_count !== 4'(i)) begin
        bad++; $display("FAIL sat_after_idle%0d got cnt=%0d want %0d", i, err_count, i);
      end
      step(8'd17, 1'b1, 1'b0);
      total++;
      if (err_count !== ((i >= 14) ? 4'd15 : 4'(i + 1)) || seq_err !== 1'b1) begin
        bad++; $display("FAIL sat_after_fault%0d got cnt=%0d err=%b", i, err_count, seq_err);
      end
    end
    step(8'd0, 1'b1, 1'b0);
    total++;
    if ({err_count, seq_err, state_dec} !== {4'd15, 1'b1, 3'd0}) begin
      bad++; $display("FAIL sat_final got cnt=%0d err=%b s=%0d want 15 1 0", err_count, seq_err, state_dec);
    end
  endtask

  task automatic test_dwell;
    do_reset(8'd0, 1'b0);
    step(8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(8'd10, 1'b1, 1'b0);
    step(8'd5, 1'b1, 1'b0);
    total++;
    if ({count_len, len_valid, seq_err, err_count} !== {8'd255, 1'b1, DWELL_ERR, 4'(DWELL_ERR)}) begin
      bad++; $display("FAIL long_dwell got len=%0d lv=%b err=%b cnt=%0d want 255 1 %b %0d",
        count_len, len_valid, seq_err, err_count, DWELL_ERR, DWELL_ERR);
    end
    // Leaving COUNT to FAULT drops the dwell without a length report
    do_reset(8'd0, 1'b0);
    step(8'd0, 1'b1, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd17, 1'b1, 1'b0);
    total++;
    if ({len_valid, count_len, seq_err} !== {1'b0, 8'd0, 1'b1}) begin
      bad++; $display("FAIL count_abort got lv=%b len=%0d err=%b want 0 0 1", len_valid, count_len, seq_err);
    end
    step(8'd0, 1'b1, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd5, 1'b1, 1'b0);
    total++;
    if ({count_len, len_valid} !== {8'd1, 1'b1}) begin
      bad++; $display("FAIL dwell_restart got len=%0d lv=%b want 1 1", count_len, len_valid);
    end
    do_reset(8'd0, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd5, 1'b1, 1'b0);
    total++;
    if ({count_len, seq_err} !== {8'd2, DWELL_ERR}) begin
      bad++; $display("FAIL short_dwell got len=%0d err=%b want 2 %b", count_len, seq_err, DWELL_ERR);
    end
  endtask

  task automatic test_sample_gate;
    logic [7:0] toggles [5] = '{8'd0, 8'd10, 8'd5, 8'd0, 8'd5};
    do_reset(8'd0, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(toggles[i], 1'b0, 1'b0);
      total++;
      if ({state_dec, trans_pulse, err_count, seq_err, rounds, len_valid} !== {3'd1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0}) begin
        bad++; $display("FAIL gated%0d got s=%0d t=%b cnt=%0d err=%b r=%0d lv=%b",
          i, state_dec, trans_pulse, err_count, seq_err, rounds, len_valid);
      end
    end
    step(8'd5, 1'b1, 1'b0);
    total++;
    if ({count_len, len_valid, state_dec} !== {8'd1, 1'b1, 3'd2}) begin
      bad++; $display("FAIL gated_dwell got len=%0d lv=%b s=%0d want 1 1 2", count_len, len_valid, state_dec);
    end
  endtask

  task automatic test_clr_vs_err;
    step(8'd17, 1'b1, 1'b0);
    step(8'd0, 1'b1, 1'b0);
    step(8'd5, 1'b1, 1'b0);
    total++;
    if (err_count !== 4'd2 + 4'(DWELL_ERR)) begin
      bad++; $display("FAIL pre_clr got cnt=%0d want %0d", err_count, 2 + DWELL_ERR);
    end
    step(8'd17, 1'b1, 1'b1);
    total++;
    if ({seq_err, err_count} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL clr_vs_err got err=%b cnt=%0d want 1 1", seq_err, err_count);
    end
    step(8'd5, 1'b0, 1'b1);
    total++;
    if ({seq_err, err_count, state_dec} !== {1'b0, 4'd0, 3'd4}) begin
      bad++; $display("FAIL clr_gated got err=%b cnt=%0d s=%0d want 0 0 4", seq_err, err_count, state_dec);
    end
  endtask

  task automatic test_rounds_wrap;
    do_reset(8'd0, 1'b0);
    for (int r = 1; r <= 256; r++) begin
      step(8'd10, 1'b1, 1'b0);
      step(8'd5, 1'b1, 1'b0);
      step(8'd15, 1'b1, 1'b0);
      total++;
      if (rounds !== 8'(r - 1)) begin
        bad++; $display("FAIL rounds_pre%0d got %0d want %0d", r, rounds, (r - 1) % 256);
      end
      step(8'd0, 1'b1, 1'b0);
      if (r == 1 || r == 255 || r == 256) begin
        total++;
        if (rounds !== 8'(r)) begin
          bad++; $display("FAIL rounds%0d got %0d want %0d", r, rounds, r % 256);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count;
    step(8'd17, 1'b1, 1'b0);
    step(8'd0, 1'b1, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    do_reset(8'd5, 1'b1);
    total++;
    if ({state_dec, trans_pulse, seq_err, err_count, count_len, len_valid, rounds} !== 26'd0) begin
      bad++; $display("FAIL reset_mid_count got %h want 0",
        {state_dec, trans_pulse, seq_err, err_count, count_len, len_valid, rounds});
    end
    step(8'd10, 1'b1, 1'b0);
    total++;
    if ({seq_err, trans_pulse, state_dec, len_valid} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin
      bad++; $display("FAIL post_reset_entry got err=%b t=%b s=%0d lv=%b want 0 1 1 0",
        seq_err, trans_pulse, state_dec, len_valid);
    end
    step(8'd5, 1'b1, 1'b0);
    total++;
    if ({count_len, len_valid} !== {8'd1, 1'b1}) begin
      bad++; $display("FAIL post_reset_dwell got len=%0d lv=%b want 1 1", count_len, len_valid);
    end
  endtask

  initial begin
    reset = 1'b0; code_in = 8'd0; sample_en = 1'b0; err_clr = 1'b0;
    test_reset;
    test_nominal;
    test_illegal_clr;
    test_saturation;
    test_dwell;
    test_sample_gate;
    test_clr_vs_err;
    test_rounds_wrap;
    test_reset_mid_count;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
